// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS32 pipeline.
// Logic, shift, arithmetic and multiply ops are combinational. DIV/DIVU run
// on an iterative restoring divider that holds the pipeline via stallreq_o.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT  = 8'h2A, OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t     state, state_nx;
    logic [CW-1:0]  cnt;
    logic [31:0]    dvd;      // dividend, shifted out MSB-first
    logic [31:0]    dvs;      // divisor magnitude
    logic [31:0]    rem;      // partial remainder
    logic [31:0]    quo;      // quotient, shifted in LSB
    logic           neg_q;
    logic           neg_r;

    logic           is_div;
    logic           is_signed_div;
    logic           start;
    logic           divisor_zero;
    logic [31:0]    abs_a;
    logic [31:0]    abs_b;
    logic [32:0]    rem_sh;
    logic           ge;
    logic [32:0]    rem_sub;
    logic [31:0]    rem_nx;

    logic [31:0]    logic_res;
    logic [31:0]    shift_res;
    logic [31:0]    arith_res;
    logic [31:0]    sel_res;
    logic [63:0]    mul_s;
    logic [63:0]    mul_u;

    assign is_div        = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_signed_div = (aluop_i == OP_DIV);
    assign start         = is_div && !annul_i;
    assign divisor_zero  = (reg2_i == 32'd0);
    assign abs_a = (is_signed_div && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
    assign abs_b = (is_signed_div && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign rem_sh  = {rem, dvd[31]};
    assign ge      = (rem_sh >= {1'b0, dvs});
    assign rem_sub = rem_sh - {1'b0, dvs};
    assign rem_nx  = ge ? rem_sub[31:0] : rem_sh[31:0];

    assign mul_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
    assign mul_u = {32'd0, reg1_i} * {32'd0, reg2_i};

    // Single-cycle result per class, unknown opcodes give 0.
    always_comb begin
        logic_res = 32'd0;
        shift_res = 32'd0;
        arith_res = 32'd0;
        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            OP_ADDU: arith_res = reg1_i + reg2_i;
            OP_SUBU: arith_res = reg1_i - reg2_i;
            OP_SLT:  arith_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLTU: arith_res = {31'd0, (reg1_i < reg2_i)};
            default: ;
        endcase
        case (alusel_i)
            3'b001:  sel_res = logic_res;
            3'b010:  sel_res = shift_res;
            3'b100:  sel_res = arith_res;
            default: sel_res = 32'd0;
        endcase
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Divider next state and all stage outputs; reset forces outputs to 0.
    always_comb begin
        state_nx   = state;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = sel_res;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        whilo_o    = 1'b0;
        stallreq_o = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stallreq_o = 1'b1;
                    state_nx   = divisor_zero ? DONE : BUSY;
                end else if (aluop_i == OP_MULT) begin
                    {hi_o, lo_o} = mul_s;
                    whilo_o      = 1'b1;
                end else if (aluop_i == OP_MULTU) begin
                    {hi_o, lo_o} = mul_u;
                    whilo_o      = 1'b1;
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_nx = IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    if (cnt == CW'(DIV_CYCLES - 1)) state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (!annul_i) begin
                    whilo_o = 1'b1;
                    lo_o    = neg_q ? (32'd0 - quo) : quo;
                    hi_o    = neg_r ? (32'd0 - rem) : rem;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            wd_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'd0;
            hi_o       = 32'd0;
            lo_o       = 32'd0;
            whilo_o    = 1'b0;
            stallreq_o = 1'b0;
        end
    end

    // Divider datapath: latch operands on start, one quotient bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            dvd   <= 32'd0;
            dvs   <= 32'd0;
            rem   <= 32'd0;
            quo   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        dvd <= abs_a;
                        dvs <= abs_b;
                        if (divisor_zero) begin
                            // Fixed result, no sign fixup applied.
                            quo   <= 32'hFFFF_FFFF;
                            rem   <= reg1_i;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            quo   <= 32'd0;
                            rem   <= 32'd0;
                            neg_q <= is_signed_div && (reg1_i[31] ^ reg2_i[31]);
                            neg_r <= is_signed_div && reg1_i[31];
                        end
                    end
                end
                BUSY: begin
                    if (!annul_i) begin
                        dvd <= {dvd[30:0], 1'b0};
                        rem <= rem_nx;
                        quo <= {quo[30:0], ge};
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with an expected-result scoreboard queue.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stallreq_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    endtask

    task automatic drive_nop();
        drive(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Compare current outputs against the oldest scoreboard entry.
    task automatic pop_check(input int stalls_seen);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".wd"},     {27'd0, wd_o},    {27'd0, e.wd});
            chk({e.tag, ".wreg"},   {31'd0, wreg_o},  {31'd0, e.wreg});
            chk({e.tag, ".wdata"},  wdata_o,          e.wdata);
            chk({e.tag, ".hi"},     hi_o,             e.hi);
            chk({e.tag, ".lo"},     lo_o,             e.lo);
            chk({e.tag, ".whilo"},  {31'd0, whilo_o}, {31'd0, e.whilo});
            chk({e.tag, ".stalls"}, stalls_seen,      e.stalls);
        end
    endtask

    // Drive one instruction at a negedge, count stall cycles, check its result.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                          input logic wr, input logic [31:0] ewdata, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic ewhilo, input int estall);
        int n = 0;
        exp_q.push_back('{tag, wd, wr, ewdata, ehi, elo, ewhilo, estall});
        @(negedge clk);
        drive(op, sel, a, b, wd, wr);
        #2;
        while (stallreq_o === 1'b1 && n < 200) begin
            n++;
            @(negedge clk); #2;
        end
        pop_check(n);
        @(negedge clk);
        drive_nop();
    endtask

    // Start a divide, let it run BUSY for a while, then kill it with annul or reset.
    task automatic abort_div(input string tag, input logic use_rst);
        @(negedge clk);
        drive(8'h1A, 3'b000, 32'd1000, 32'd7, 5'd3, 1'b0);
        repeat (11) @(negedge clk);   // IDLE cycle + 10 BUSY cycles
        #2;
        chk({tag, ".stall_busy"}, {31'd0, stallreq_o}, 32'd1);
        @(negedge clk);
        if (use_rst) rst = 1'b1; else annul_i = 1'b1;
        #2;
        chk({tag, ".stall_kill"}, {31'd0, stallreq_o}, 32'd0);
        chk({tag, ".whilo_kill"}, {31'd0, whilo_o}, 32'd0);
        if (use_rst) begin
            chk({tag, ".wdata_rst"}, wdata_o, 32'd0);
            chk({tag, ".hi_rst"},    hi_o,    32'd0);
            chk({tag, ".lo_rst"},    lo_o,    32'd0);
            chk({tag, ".wd_rst"},    {27'd0, wd_o}, 32'd0);
        end
        @(negedge clk); #2;
        // Killed divide is idle: with annul still up the DIV inputs cannot restart it.
        if (!use_rst) begin
            chk({tag, ".stall_after"}, {31'd0, stallreq_o}, 32'd0);
            chk({tag, ".whilo_after"}, {31'd0, whilo_o},    32'd0);
        end
        rst = 1'b0; annul_i = 1'b0;
        drive_nop();
        @(negedge clk); #2;
        chk({tag, ".stall_idle"}, {31'd0, stallreq_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; annul_i = 1'b0;
        drive(8'h21, 3'b100, 32'h1234, 32'h1, 5'd9, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        chk("rst.wd",       {27'd0, wd_o},       32'd0);
        chk("rst.wreg",     {31'd0, wreg_o},     32'd0);
        chk("rst.wdata",    wdata_o,             32'd0);
        chk("rst.hi",       hi_o,                32'd0);
        chk("rst.lo",       lo_o,                32'd0);
        chk("rst.whilo",    {31'd0, whilo_o},    32'd0);
        chk("rst.stall",    {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;
        drive_nop();

        //      tag     op     sel     reg1          reg2          wd  wr  wdata          hi             lo             whilo stall
        run_op("addu", 8'h21, 3'b100, 32'hFFFFFFFF, 32'h00000002, 5, 1, 32'h00000001, 0, 0, 0, 0);
        run_op("subu", 8'h23, 3'b100, 32'h00000001, 32'h00000003, 6, 1, 32'hFFFFFFFE, 0, 0, 0, 0);
        run_op("sra",  8'h03, 3'b010, 32'h00000004, 32'h80000000, 7, 1, 32'hF8000000, 0, 0, 0, 0);
        run_op("srl",  8'h02, 3'b010, 32'h00000004, 32'h80000000, 7, 1, 32'h08000000, 0, 0, 0, 0);
        run_op("sll",  8'h7C, 3'b010, 32'h0000001F, 32'h00000003, 8, 1, 32'h80000000, 0, 0, 0, 0);
        run_op("slt",  8'h2A, 3'b100, 32'hFFFFFFFF, 32'h00000001, 9, 1, 32'h00000001, 0, 0, 0, 0);
        run_op("sltu", 8'h2B, 3'b100, 32'hFFFFFFFF, 32'h00000001, 9, 1, 32'h00000000, 0, 0, 0, 0);
        run_op("and",  8'h24, 3'b001, 32'hF0F0FF00, 32'hFF00F0F0, 1, 1, 32'hF000F000, 0, 0, 0, 0);
        run_op("or",   8'h25, 3'b001, 32'hF0F0FF00, 32'hFF00F0F0, 1, 1, 32'hFFF0FFF0, 0, 0, 0, 0);
        run_op("xor",  8'h26, 3'b001, 32'hF0F0FF00, 32'hFF00F0F0, 1, 1, 32'h0FF00FF0, 0, 0, 0, 0);
        run_op("nor",  8'h27, 3'b001, 32'hF0F0FF00, 32'hFF00F0F0, 1, 1, 32'h000F000F, 0, 0, 0, 0);
        run_op("unk",  8'h77, 3'b100, 32'h12345678, 32'h1, 2, 1, 32'h0, 0, 0, 0, 0);
        run_op("sel0", 8'h21, 3'b000, 32'h12345678, 32'h1, 2, 1, 32'h0, 0, 0, 0, 0);
        run_op("mult", 8'h18, 3'b101, 32'hFFFFFFFE, 32'h00000003, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1, 0);
        run_op("multu",8'h19, 3'b101, 32'hFFFFFFFE, 32'h00000003, 0, 0, 0, 32'h00000002, 32'hFFFFFFFA, 1, 0);
        run_op("div",  8'h1A, 3'b000, 32'hFFFFFFF9, 32'h00000002, 4, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 33);
        run_op("divu", 8'h1B, 3'b000, 32'd100,      32'd7,        4, 0, 0, 32'd2,        32'd14,       1, 33);
        run_op("divs", 8'h1A, 3'b000, 32'd100,      32'hFFFFFFF9, 4, 0, 0, 32'd2,        32'hFFFFFFF2, 1, 33);
        run_op("div0", 8'h1B, 3'b000, 32'd5,        32'd0,        4, 0, 0, 32'd5,        32'hFFFFFFFF, 1, 1);

        abort_div("annul", 1'b0);
        run_op("divu_post_annul", 8'h1B, 3'b000, 32'd9, 32'd3, 2, 0, 0, 32'd0, 32'd3, 1, 33);
        abort_div("rstdiv", 1'b1);
        run_op("divu_post_rst",   8'h1B, 3'b000, 32'd9, 32'd3, 2, 0, 0, 32'd0, 32'd3, 1, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
